// File: rtl/fpga_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_cfg_pkg
// Description : Shared configuration for the Sobol sequencing path: default
//               datapath width, default tag depth, the controller state type
//               and the tag carried alongside every outstanding request.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_cfg_pkg;

    // Default sample / index / path-count width of the datapath.
    localparam int FP_WIDTH = 32;

    // Default number of generator requests allowed in flight.
    localparam int SOBOL_TAG_DEPTH = 4;

    // Tag field widths are fixed here so the FIFO type is shared by every
    // controller instance; controllers zero-extend into and truncate out of
    // these fields. The dim field covers M up to 65536.
    localparam int SOBOL_TAG_PATH_W = FP_WIDTH;
    localparam int SOBOL_TAG_DIM_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sobol_seq_state_t;

    typedef struct packed {
        logic [SOBOL_TAG_PATH_W-1:0] path;
        logic [SOBOL_TAG_DIM_W-1:0]  dim;
        logic                        last_dim;
        logic                        last;
    } sobol_tag_t;

endpackage
`default_nettype wire

// File: rtl/sobol_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sobol_tag_fifo
// Description : Synchronous FIFO of sobol_tag_t entries. Holds the tag of
//               every generator request that has not yet been returned
//               downstream. Pushes while full and pops while empty are
//               dropped.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push, wdata     - write strobe and tag
//               pop             - read strobe (advances the head)
//               rdata           - head entry (valid when !empty)
//               count           - entries held, 0..DEPTH
//               full, empty     - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module sobol_tag_fifo
    import fpga_cfg_pkg::*;
#(
    parameter int DEPTH = SOBOL_TAG_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  sobol_tag_t               wdata,
    input  logic                     pop,
    output sobol_tag_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    sobol_tag_t      mem_q [DEPTH];
    sobol_tag_t      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/sobol_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sobol_seq_ctrl
// Description : Sequencing controller for one Sobol generator lane. Walks
//               every (path, time-step) point of the lane in path-major
//               order, issues row-index / dimension requests, tags each
//               returned sample and forwards it downstream. In-flight
//               requests are bounded by TAG_DEPTH so no tag is lost.
// Config      : SOBOL_SKIP_ZERO_EN - when defined the first row index is
//               LANE_ID+1 (skips the all-zero Sobol point); otherwise the
//               first row index is LANE_ID.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               start, num_paths           - run request (IDLE only)
//               busy, done                 - run status / completion pulse
//               gen_valid/ready/idx/dim    - request channel to generator
//               gen_rsp_valid/ready/data   - sample channel from generator
//               u_valid/ready/data         - downstream sample channel
//               u_path/dim/last_dim/last   - tag of the current sample
// Revision    : 1.0 - initial release
// ============================================================================
module sobol_seq_ctrl
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int M         = 50,
    parameter int LANE_ID   = 0,
    parameter int NUM_LANES = 1,
    parameter int TAG_DEPTH = SOBOL_TAG_DEPTH,
    localparam int DW       = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num_paths,
    output logic             busy,
    output logic             done,
    output logic             gen_valid,
    input  logic             gen_ready,
    output logic [WIDTH-1:0] gen_idx,
    output logic [DW-1:0]    gen_dim,
    input  logic             gen_rsp_valid,
    output logic             gen_rsp_ready,
    input  logic [WIDTH-1:0] gen_rsp_data,
    output logic             u_valid,
    input  logic             u_ready,
    output logic [WIDTH-1:0] u_data,
    output logic [WIDTH-1:0] u_path,
    output logic [DW-1:0]    u_dim,
    output logic             u_last_dim,
    output logic             u_last
);

`ifdef SOBOL_SKIP_ZERO_EN
    localparam int IDX_SKIP = 1;
`else
    localparam int IDX_SKIP = 0;
`endif

    localparam int CW = $clog2(TAG_DEPTH) + 1;

    localparam logic [WIDTH-1:0] IDX_FIRST = WIDTH'(LANE_ID + IDX_SKIP);
    localparam logic [WIDTH-1:0] IDX_STEP  = WIDTH'(NUM_LANES);
    localparam logic [WIDTH-1:0] PATH_ONE  = WIDTH'(1);
    localparam logic [DW-1:0]    DIM_ONE   = DW'(1);
    localparam logic [DW-1:0]    DIM_LAST  = DW'(M - 1);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);

    sobol_seq_state_t  state_q, state_d;
    logic [WIDTH-1:0]  np_q,    np_d;
    logic [WIDTH-1:0]  path_q,  path_d;
    logic [DW-1:0]     dim_q,   dim_d;
    logic [WIDTH-1:0]  idx_q,   idx_d;

    logic              req_fire;
    logic              rsp_fire;
    logic              start_run;
    logic              start_empty;
    logic              dim_at_last;
    logic              point_last;
    sobol_tag_t        push_tag;
    sobol_tag_t        head_tag;
    logic              head_unused;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign req_fire    = gen_valid && gen_ready;
    assign rsp_fire    = u_valid && u_ready;
    assign start_run   = (state_q == ST_IDLE) && start && (num_paths != '0);
    assign start_empty = (state_q == ST_IDLE) && start && (num_paths == '0);
    assign dim_at_last = (dim_q == DIM_LAST);
    assign point_last  = dim_at_last && (path_q == (np_q - PATH_ONE));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_run) begin
                    state_d = ST_RUN;
                end else if (start_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                if (req_fire && point_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave once the final outstanding sample has been accepted.
                if (fifo_empty || (fifo_count == CNT_ONE && rsp_fire)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
        // Request valid depends only on state and occupancy, never on ready.
        gen_valid = (state_q == ST_RUN) && !fifo_full;
    end

    // ----------------------------------------------------- point counters
    always_comb begin
        np_d   = np_q;
        path_d = path_q;
        dim_d  = dim_q;
        idx_d  = idx_q;
        if (start_run) begin
            np_d   = num_paths;
            path_d = '0;
            dim_d  = '0;
            idx_d  = IDX_FIRST;
        end else if (req_fire) begin
            if (dim_at_last) begin
                dim_d  = '0;
                path_d = path_q + PATH_ONE;
                // Row index wraps modulo 2^WIDTH by plain overflow.
                idx_d  = idx_q + IDX_STEP;
            end else begin
                dim_d  = dim_q + DIM_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            np_q   <= '0;
            path_q <= '0;
            dim_q  <= '0;
            idx_q  <= '0;
        end else begin
            np_q   <= np_d;
            path_q <= path_d;
            dim_q  <= dim_d;
            idx_q  <= idx_d;
        end
    end

    assign gen_idx = idx_q;
    assign gen_dim = dim_q;

    // ------------------------------------------------------------ tag FIFO
    always_comb begin
        push_tag          = '0;
        push_tag.path     = SOBOL_TAG_PATH_W'(path_q);
        push_tag.dim      = SOBOL_TAG_DIM_W'(dim_q);
        push_tag.last_dim = dim_at_last;
        push_tag.last     = point_last;
    end

    sobol_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_fire),
        .wdata (push_tag),
        .pop   (rsp_fire),
        .rdata (head_tag),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Upper tag bits beyond WIDTH / DW are never read back.
    assign head_unused = ^head_tag;

    // --------------------------------------------------------- return path
    assign u_valid       = gen_rsp_valid;
    assign gen_rsp_ready = u_ready;
    assign u_data        = gen_rsp_data;

    // Tag outputs read as zero while nothing is outstanding.
    assign u_path     = fifo_empty ? '0 : WIDTH'(head_tag.path);
    assign u_dim      = fifo_empty ? '0 : DW'(head_tag.dim);
    assign u_last_dim = !fifo_empty && head_tag.last_dim;
    assign u_last     = !fifo_empty && head_tag.last;

    // A sample with no outstanding request cannot be tagged.
    a_rsp_has_tag : assert property (@(posedge clk) disable iff (!rst_n)
        !(gen_rsp_valid && fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_sobol_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sobol_seq_ctrl
// Description : Scoreboard bench for sobol_seq_ctrl. Expected request and
//               sample streams are generated from the path-major walk rules
//               when a run is started; a monitor compares every handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobol_seq_ctrl;

    localparam int WIDTH     = 8;
    localparam int M         = 4;
    localparam int LANE_ID   = 2;
    localparam int NUM_LANES = 3;
    localparam int TAG_DEPTH = 4;
    localparam int DW        = $clog2(M);
`ifdef SOBOL_SKIP_ZERO_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] num_paths;
    logic             busy, done;
    logic             gen_valid;
    logic             gen_ready;
    logic [WIDTH-1:0] gen_idx;
    logic [DW-1:0]    gen_dim;
    logic             gen_rsp_valid;
    logic             gen_rsp_ready;
    logic [WIDTH-1:0] gen_rsp_data;
    logic             u_valid;
    logic             u_ready;
    logic [WIDTH-1:0] u_data, u_path;
    logic [DW-1:0]    u_dim;
    logic             u_last_dim, u_last;

    sobol_seq_ctrl #(
        .WIDTH(WIDTH), .M(M), .LANE_ID(LANE_ID),
        .NUM_LANES(NUM_LANES), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_paths(num_paths),
        .busy(busy), .done(done),
        .gen_valid(gen_valid), .gen_ready(gen_ready),
        .gen_idx(gen_idx), .gen_dim(gen_dim),
        .gen_rsp_valid(gen_rsp_valid), .gen_rsp_ready(gen_rsp_ready),
        .gen_rsp_data(gen_rsp_data),
        .u_valid(u_valid), .u_ready(u_ready), .u_data(u_data),
        .u_path(u_path), .u_dim(u_dim),
        .u_last_dim(u_last_dim), .u_last(u_last)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int dim; } req_t;
    typedef struct { int data; int path; int dim; bit last_dim; bit last; } smp_t;

    req_t exp_req_q[$];
    smp_t exp_u_q[$];
    req_t gen_q[$];

    int checks = 0;
    int errors = 0;
    int gr_mode = 0;   // 0: gen_ready high, 1: random
    int ur_mode = 0;   // 0: u_ready high, 1: random, 2: held low
    int rv_mode = 0;   // 0: respond as soon as possible, 1: random gaps

    // Monitor-side model of the controller's externally visible status.
    bit   run_active = 0;
    bit   exp_done   = 0;
    bit   stall_chk  = 0;
    int   st_idx, st_dim;
    int   outstanding = 0;

    function automatic int sample_of(int idx, int dim);
        return (idx * 7 + dim * 29 + 11) & 8'hFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Generator and downstream stimulus.
    always @(negedge clk) begin
        gen_ready = (gr_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        u_ready   = (ur_mode == 0) ? 1'b1 :
                    (ur_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (rst_n && gen_q.size() > 0 && (rv_mode == 0 || $urandom_range(0, 3) != 0)) begin
            gen_rsp_valid = 1'b1;
            gen_rsp_data  = WIDTH'(sample_of(gen_q[0].idx, gen_q[0].dim));
        end else begin
            gen_rsp_valid = 1'b0;
            gen_rsp_data  = WIDTH'($urandom);
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        req_t r;
        smp_t e;
        bit   start_acc;
        bit   u_fire;
        bit   last_fire;
        #1;
        if (!rst_n) begin
            run_active  = 0;
            exp_done    = 0;
            stall_chk   = 0;
            outstanding = 0;
        end else begin
            if (exp_done || done) chk("done_pulse", done, exp_done);
            chk("busy", busy, run_active);
            chk("gen_valid", gen_valid,
                run_active && exp_req_q.size() > 0 && outstanding < TAG_DEPTH);
            chk("rsp_ready_pass", gen_rsp_ready, u_ready);
            if (stall_chk) begin
                chk("stall_valid", gen_valid, 1);
                chk("stall_idx", gen_idx, st_idx);
                chk("stall_dim", gen_dim, st_dim);
            end
            if (gen_valid && gen_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req actual_idx=%0d required=none", gen_idx);
                end else begin
                    r = exp_req_q.pop_front();
                    chk("gen_idx", gen_idx, r.idx);
                    chk("gen_dim", gen_dim, r.dim);
                end
                gen_q.push_back('{int'(gen_idx), int'(gen_dim)});
                outstanding++;
            end
            stall_chk = gen_valid && !gen_ready;
            st_idx    = gen_idx;
            st_dim    = gen_dim;
            u_fire    = u_valid && u_ready;
            last_fire = 0;
            if (u_fire) begin
                if (exp_u_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_sample actual_data=%0d required=none", u_data);
                end else begin
                    e = exp_u_q.pop_front();
                    chk("u_data", u_data, e.data);
                    chk("u_path", u_path, e.path);
                    chk("u_dim", u_dim, e.dim);
                    chk("u_last_dim", u_last_dim, e.last_dim);
                    chk("u_last", u_last, e.last);
                    last_fire = e.last;
                end
                if (gen_q.size() > 0) void'(gen_q.pop_front());
                outstanding--;
            end
            start_acc = start && !run_active && !exp_done;
            exp_done  = last_fire || (start_acc && num_paths == 0);
            if (last_fire) run_active = 0;
            if (start_acc && num_paths != 0) run_active = 1;
        end
    end

    task automatic launch(input int np);
        int idx;
        @(negedge clk);
        start     = 1'b1;
        num_paths = WIDTH'(np);
        for (int p = 0; p < np; p++) begin
            idx = (LANE_ID + SKIP + p * NUM_LANES) % 256;
            for (int d = 0; d < M; d++) begin
                exp_req_q.push_back('{idx, d});
                exp_u_q.push_back('{sample_of(idx, d), p, d, d == M - 1,
                                    (p == np - 1) && (d == M - 1)});
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            #2;
            cyc++;
            if (done) break;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done required=done within %0d cycles", budget);
        end
        chk("req_stream_drained", exp_req_q.size(), 0);
        chk("smp_stream_drained", exp_u_q.size(), 0);
    endtask

    task automatic set_modes(input int g, input int u, input int v);
        gr_mode = g; ur_mode = u; rv_mode = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; num_paths = '0;
        gen_ready = 1'b0; u_ready = 1'b0; gen_rsp_valid = 1'b0; gen_rsp_data = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gen_valid", gen_valid, 0);
        chk("rst_gen_idx", gen_idx, 0);
        chk("rst_gen_dim", gen_dim, 0);
        chk("rst_u_path", u_path, 0);
        chk("rst_u_dim", u_dim, 0);
        chk("rst_u_last", u_last, 0);
        chk("rst_u_last_dim", u_last_dim, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full throughput, 3 paths: done one cycle after the last sample.
        set_modes(0, 0, 0);
        launch(3);
        wait_done(200, cyc);
        chk("throughput_latency", cyc, 3 * M + 1);

        // Random backpressure on every channel.
        set_modes(1, 1, 1);
        launch(5);
        wait_done(2000, cyc);

        // Long run: row index wraps past 2^WIDTH.
        launch(90);
        wait_done(5000, cyc);

        // Downstream stalled for 10 cycles: request issue must stop at TAG_DEPTH.
        set_modes(0, 0, 0);
        launch(6);
        repeat (3) @(negedge clk);
        ur_mode = 2;
        repeat (10) @(negedge clk);
        #2;
        chk("stall_gen_valid_low", gen_valid, 0);
        ur_mode = 0;
        wait_done(500, cyc);

        // Zero paths: no requests, done on the next cycle.
        @(negedge clk);
        start = 1'b1; num_paths = '0;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("zero_done", done, 1);
        chk("zero_gen_valid", gen_valid, 0);
        chk("zero_busy", busy, 0);
        @(negedge clk);
        #2;
        chk("zero_done_once", done, 0);

        // Start while busy is ignored.
        set_modes(1, 1, 1);
        launch(4);
        repeat (5) @(negedge clk);
        start = 1'b1; num_paths = WIDTH'(7);
        @(negedge clk);
        start = 1'b0;
        wait_done(2000, cyc);

        // Asynchronous reset mid-run, then a fresh run.
        launch(20);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_gen_valid", gen_valid, 0);
        chk("async_done", done, 0);
        chk("async_gen_idx", gen_idx, 0);
        chk("async_gen_dim", gen_dim, 0);
        chk("async_u_path", u_path, 0);
        chk("async_u_last", u_last, 0);
        exp_req_q.delete();
        exp_u_q.delete();
        gen_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_modes(0, 0, 0);
        repeat (3) @(negedge clk);
        launch(2);
        wait_done(200, cyc);
        chk("restart_latency", cyc, 2 * M + 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
